// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode queue bus.
// Groups the fetch-side push handshake, the flush request, the decode-side
// pop handshake with the pre-split MIPS fields, and the occupancy/starve
// status counters.
//   slave  : the queue itself (receives pushes, presents the head)
//   master : the fetch/decode environment driving the queue
interface fetch_decode_queue_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [5:0]    out_opcode;
  logic [4:0]    out_rs;
  logic [4:0]    out_rt;
  logic [4:0]    out_rd;
  logic [4:0]    out_shamt;
  logic [5:0]    out_funct;
  logic [15:0]   out_imm16;
  logic [25:0]   out_target;
  logic [AW:0]   count;
  logic [15:0]   starve_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_target, count, starve_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm16, out_target, count, starve_cnt
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode.
// Stores {pc, instr} pairs pushed by fetch and presents the oldest one to
// decode with first-word fall-through, already sliced into MIPS fields.
// A flush discards all queued wrong-path work. starve_cnt counts cycles in
// which decode was ready but nothing was queued.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   q     : queue bus (slave side), see fetch_decode_queue_if
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_decode_queue_if.slave  q
);

  logic [DEPTH-1:0][63:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            cnt;
  logic [15:0]            starve_q, starve_nxt;
  logic                   full, nempty, push, pop;
  logic [63:0]            head;

  // Handshake depends on occupancy only, never on the partner's valid/ready.
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign nempty = (cnt != '0);
  assign push   = q.in_valid & ~full;
  assign pop    = nempty & q.out_ready;

  // Saturating; flush cycles are not counted as starvation.
  assign starve_nxt = (q.out_ready && !nempty && !q.flush && starve_q != 16'hFFFF)
                      ? starve_q + 16'd1 : starve_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_nxt;
      if (q.flush) begin
        // Storage is left as is; count=0 hides it.
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {q.in_pc, q.in_instr};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Empty queue reads as all-zero, which decodes as sll $0,$0,0.
  assign head = nempty ? mem[rd_ptr] : 64'd0;

  assign q.in_ready   = ~full;
  assign q.out_valid  = nempty;
  assign q.out_pc     = head[63:32];
  assign q.out_instr  = head[31:0];
  assign q.out_opcode = head[31:26];
  assign q.out_rs     = head[25:21];
  assign q.out_rt     = head[20:16];
  assign q.out_rd     = head[15:11];
  assign q.out_shamt  = head[10:6];
  assign q.out_funct  = head[5:0];
  assign q.out_imm16  = head[15:0];
  assign q.out_target = head[25:0];
  assign q.count      = cnt;
  assign q.starve_cnt = starve_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;
  logic clk;
  logic rst_n;
  int   vec;
  int   errs;

  fetch_decode_queue_if #(.AW(2)) bus ();

  fetch_decode_queue #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.in_pc     = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 ||
        bus.out_instr !== 32'd0 || bus.starve_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_state: valid=%b count=%0d ready=%b instr=%h starve=%h, want 0 0 1 0 0",
               bus.out_valid, bus.count, bus.in_ready, bus.out_instr, bus.starve_cnt);
    end
    apply_reset();
    for (int i = 0; i < 3; i++) push_word(32'h10 + 32'(i*4), 32'h2000_0000 + 32'(i));
    vec++;
    if (bus.count !== 3'd3 || bus.out_pc !== 32'h10) begin
      errs++;
      $display("FAIL pre_async: count=%0d pc=%h, want 3 00000010", bus.count, bus.out_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 ||
        bus.out_instr !== 32'd0 || bus.out_pc !== 32'd0) begin
      errs++;
      $display("FAIL async_reset: valid=%b count=%0d ready=%b instr=%h pc=%h, want 0 0 1 0 0",
               bus.out_valid, bus.count, bus.in_ready, bus.out_instr, bus.out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 4; i++) push_word(32'(i*4), 32'h8C22_0004);
    vec++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL full: count=%0d ready=%b, want 4 0", bus.count, bus.in_ready);
    end
    push_word(32'd16, 32'hDEAD_BEEF);
    vec++;
    if (bus.count !== 3'd4) begin
      errs++;
      $display("FAIL push_when_full: count=%0d, want 4", bus.count);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i*4) || bus.out_opcode !== 6'h23 ||
          bus.out_rs !== 5'd1 || bus.out_rt !== 5'd2 || bus.out_imm16 !== 16'h0004) begin
        errs++;
        $display("FAIL drain[%0d]: valid=%b pc=%h op=%h rs=%0d rt=%0d imm=%h, want 1 %h 23 1 2 0004",
                 i, bus.out_valid, bus.out_pc, bus.out_opcode, bus.out_rs, bus.out_rt,
                 bus.out_imm16, 32'(i*4));
      end
      step();
    end
    bus.out_ready = 1'b0;
    vec++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 ||
        bus.out_pc !== 32'd0) begin
      errs++;
      $display("FAIL drained_empty: count=%0d valid=%b instr=%h pc=%h, want 0 0 0 0",
               bus.count, bus.out_valid, bus.out_instr, bus.out_pc);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_word(32'h100, 32'h1111_0000);
    push_word(32'h104, 32'h1111_0001);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_pc    = 32'h108 + 32'(i*4);
      bus.in_instr = 32'h1111_0002 + 32'(i);
      vec++;
      if (bus.count !== 3'd2 || bus.out_pc !== 32'h100 + 32'(i*4) ||
          bus.out_instr !== 32'h1111_0000 + 32'(i)) begin
        errs++;
        $display("FAIL b2b[%0d]: count=%0d pc=%h instr=%h, want 2 %h %h", i, bus.count,
                 bus.out_pc, bus.out_instr, 32'h100 + 32'(i*4), 32'h1111_0000 + 32'(i));
      end
      step();
    end
    idle_inputs();
    vec++;
    if (bus.count !== 3'd2 || bus.out_pc !== 32'h118) begin
      errs++;
      $display("FAIL b2b_end: count=%0d pc=%h, want 2 00000118", bus.count, bus.out_pc);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) push_word(32'h200 + 32'(i*4), 32'h3333_0000 + 32'(i));
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h300;
    bus.in_instr  = 32'hBAD0_BAD0;
    bus.out_ready = 1'b1;
    step();
    idle_inputs();
    vec++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'd0) begin
      errs++;
      $display("FAIL flush: count=%0d valid=%b pc=%h, want 0 0 0", bus.count, bus.out_valid,
               bus.out_pc);
    end
    push_word(32'h400, 32'h4444_0000);
    vec++;
    if (bus.count !== 3'd1 || bus.out_pc !== 32'h400 || bus.out_instr !== 32'h4444_0000) begin
      errs++;
      $display("FAIL post_flush: count=%0d pc=%h instr=%h, want 1 00000400 44440000",
               bus.count, bus.out_pc, bus.out_instr);
    end
  endtask

  task automatic test_starve();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.out_ready = 1'b0;
    vec++;
    if (bus.starve_cnt !== 16'd5) begin
      errs++;
      $display("FAIL starve_5: got %h, want 0005", bus.starve_cnt);
    end
    force dut.starve_q = 16'hFFFE;
    step();
    release dut.starve_q;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.out_ready = 1'b0;
    vec++;
    if (bus.starve_cnt !== 16'hFFFF) begin
      errs++;
      $display("FAIL starve_sat: got %h, want ffff", bus.starve_cnt);
    end
  endtask

  task automatic test_fields();
    apply_reset();
    push_word(32'h40, 32'h0085_1020);
    vec++;
    if (bus.out_opcode !== 6'd0 || bus.out_rs !== 5'd4 || bus.out_rt !== 5'd5 ||
        bus.out_rd !== 5'd2 || bus.out_shamt !== 5'd0 || bus.out_funct !== 6'h20 ||
        bus.out_imm16 !== 16'h1020 || bus.out_target !== 26'h085_1020) begin
      errs++;
      $display("FAIL fields: op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h imm=%h tgt=%h, want 00 4 5 2 0 20 1020 0851020",
               bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
               bus.out_funct, bus.out_imm16, bus.out_target);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_starve();
    test_fields();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
